// File: rtl/int_ctrl_if.sv
// Handshake bundle between the interrupt controller and the CPU core.
// The controller takes the slave modport; the CPU (or a bench) takes the master modport.
interface int_ctrl_if;
    logic        i_ea;
    logic [4:0]  i_ie;
    logic [4:0]  i_ip;
    logic [4:0]  i_req;
    logic        i_ack;
    logic        i_reti;
    logic        o_irq;
    logic [15:0] o_vector;
    logic [2:0]  o_src;
    logic [4:0]  o_clr;
    logic        o_in_prog;

    modport master (
        output i_ea, i_ie, i_ip, i_req, i_ack, i_reti,
        input  o_irq, o_vector, o_src, o_clr, o_in_prog
    );

    modport slave (
        input  i_ea, i_ie, i_ip, i_req, i_ack, i_reti,
        output o_irq, o_vector, o_src, o_clr, o_in_prog
    );
endinterface

// File: rtl/int_ctrl.sv
// 8051-style interrupt controller: five sources, arbitration, vector generation and ISR nesting.
// Define INT_PRIORITY_EN for two-level priority with nesting; otherwise one level, no nesting.
module int_ctrl (
    input  logic      i_clk,
    input  logic      i_rst,
    int_ctrl_if.slave bus
);
    localparam int N_SRC = 5;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t      state_reg;
    logic        act_hi_reg;
    logic        act_lo_reg;
    logic        pri_reg;
    logic        irq_reg;
    logic [2:0]  src_reg;
    logic [15:0] vector_reg;
    logic [4:0]  clr_reg;
    logic        in_prog_reg;

    logic        act_hi_next;
    logic        act_lo_next;
    logic        ack_taken;
    logic [4:0]  elig;
    logic [4:0]  hi_mask;
    logic [4:0]  cand;
    logic [4:0]  cand_hi;
    logic [4:0]  pick_set;
    logic [4:0]  win_onehot;
    logic [2:0]  win_idx;
    logic        win_valid;
    logic        win_hi;
    logic [15:0] win_vector;

    assign ack_taken = (state_reg == ST_PEND) && bus.i_ack;
    assign elig      = bus.i_req & bus.i_ie & {N_SRC{bus.i_ea}};

`ifdef INT_PRIORITY_EN
    assign hi_mask = bus.i_ip;
`else
    assign hi_mask = '0;
`endif

    // The accepting cycle never yields a candidate, which forces a pass through IDLE.
    always_comb begin
        cand = elig;
        if (act_hi_reg) begin
            cand = '0;
        end else if (act_lo_reg) begin
            cand = elig & hi_mask;
        end
        if (ack_taken) begin
            cand = '0;
        end
    end

    assign cand_hi   = cand & hi_mask;
    assign pick_set  = (|cand_hi) ? cand_hi : cand;
    assign win_valid = |cand;
    assign win_hi    = |cand_hi;

    // Lowest index of the chosen priority group wins.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign win_onehot[gi] = pick_set[gi];
            end else begin : g_rest
                assign win_onehot[gi] = pick_set[gi] & ~(|pick_set[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        win_idx = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_onehot[i]) begin
                win_idx = win_idx | 3'(i);
            end
        end
    end

    // Vectors sit 8 bytes apart starting at 0x0003.
    assign win_vector = 16'h0003 + {10'd0, win_idx, 3'b000};

    // RETI unwinds first, then an accepted vector pushes its own level.
    always_comb begin
        act_hi_next = act_hi_reg;
        act_lo_next = act_lo_reg;
        if (bus.i_reti) begin
            if (act_hi_reg) begin
                act_hi_next = 1'b0;
            end else begin
                act_lo_next = 1'b0;
            end
        end
        if (ack_taken) begin
            if (pri_reg) begin
                act_hi_next = 1'b1;
            end else begin
                act_lo_next = 1'b1;
            end
        end
`ifndef INT_PRIORITY_EN
        act_hi_next = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            act_hi_reg  <= 1'b0;
            act_lo_reg  <= 1'b0;
            pri_reg     <= 1'b0;
            irq_reg     <= 1'b0;
            src_reg     <= 3'd0;
            vector_reg  <= 16'h0000;
            clr_reg     <= 5'd0;
            in_prog_reg <= 1'b0;
        end else begin
            act_hi_reg  <= act_hi_next;
            act_lo_reg  <= act_lo_next;
            in_prog_reg <= act_hi_next | act_lo_next;
            clr_reg     <= 5'd0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_reg  <= ST_PEND;
                        irq_reg    <= 1'b1;
                        src_reg    <= win_idx;
                        vector_reg <= win_vector;
                        pri_reg    <= win_hi;
                    end
                end
                ST_PEND: begin
                    if (bus.i_ack) begin
                        state_reg <= ST_IDLE;
                        irq_reg   <= 1'b0;
                        clr_reg   <= 5'b00001 << src_reg;
                    end else if (win_valid) begin
                        src_reg    <= win_idx;
                        vector_reg <= win_vector;
                        pri_reg    <= win_hi;
                    end else begin
                        state_reg <= ST_IDLE;
                        irq_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    irq_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_irq     = irq_reg;
    assign bus.o_vector  = vector_reg;
    assign bus.o_src     = src_reg;
    assign bus.o_clr     = clr_reg;
    assign bus.o_in_prog = in_prog_reg;

endmodule
